// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - queue-side and bit-stream-side signals of the serializer
interface serializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             enable_in;
    logic             queue_empty_in;
    logic [WIDTH-1:0] data_in;
    logic             dequeue_out;
    logic             ready_in;
    logic             data_out;
    logic             write_out;
    logic             busy_out;
    logic             word_done_out;
    logic [CNT_W-1:0] words_sent_out;

    modport slave (
        input  enable_in, queue_empty_in, data_in, ready_in,
        output dequeue_out, data_out, write_out, busy_out, word_done_out, words_sent_out
    );

    modport master (
        output enable_in, queue_empty_in, data_in, ready_in,
        input  dequeue_out, data_out, write_out, busy_out, word_done_out, words_sent_out
    );
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - pops words from a queue and shifts them out one bit per ready cycle
module serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic        clock1M,
    input  logic        reset,
    serializer_if.slave bus
);
    localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, REQ, LOAD, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dequeue_q, dequeue_d;
    logic             data_q, data_d;
    logic             write_q, write_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             next_bit;

    assign next_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

    always_ff @(posedge clock1M) begin
        if (reset) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            dequeue_q <= 1'b0;
            data_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            dequeue_q <= dequeue_d;
            data_q    <= data_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sent_q    <= sent_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        dequeue_d = 1'b0;
        data_d    = 1'b0;
        write_d   = 1'b0;
        done_d    = 1'b0;
        sent_d    = sent_q;
        case (state_q)
            IDLE: begin
                if (bus.enable_in && !bus.queue_empty_in) begin
                    state_d   = REQ;
                    dequeue_d = 1'b1;
                end
            end
            REQ: state_d = LOAD;
            LOAD: begin
                // data_in is valid now: the queue answers the cycle after the pop
                sreg_d    = bus.data_in;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                data_d = data_q;
                if (bus.ready_in) begin
                    data_d    = next_bit;
                    write_d   = 1'b1;
                    sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        sent_d  = sent_q + CNT_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.dequeue_out    = dequeue_q;
    assign bus.data_out       = data_q;
    assign bus.write_out      = write_q;
    assign bus.busy_out       = busy_q;
    assign bus.word_done_out  = done_q;
    assign bus.words_sent_out = sent_q;
endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed checks of serializer in MSB-first and LSB-first builds
module tb_serializer;
    logic clock1M = 1'b0;
    logic reset;
    always #5 clock1M = ~clock1M;

    serializer_if #(.WIDTH(8), .CNT_W(16)) a ();
    serializer_if #(.WIDTH(8), .CNT_W(2))  b ();

    serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
        .clock1M(clock1M), .reset(reset), .bus(a.slave));
    serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(2)) dut_b (
        .clock1M(clock1M), .reset(reset), .bus(b.slave));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] qa[$], qb[$];
    logic       bits_a[$], bits_b[$];
    int         wcyc_a[$];
    int         deq_a = 0, deq_b = 0, done_a = 0, done_pos_a = 0, deq_cyc_a = 0;
    logic [7:0] v;
    int         t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock1M);
        cyc++;
        if (a.write_out) begin bits_a.push_back(a.data_out); wcyc_a.push_back(cyc); end
        if (a.word_done_out) begin done_a++; done_pos_a = bits_a.size(); end
        if (a.dequeue_out) begin
            deq_a++; deq_cyc_a = cyc;
            a.data_in = (qa.size() > 0) ? qa.pop_front() : 8'h00;
        end
        a.queue_empty_in = (qa.size() == 0);
        if (b.write_out) bits_b.push_back(b.data_out);
        if (b.dequeue_out) begin
            deq_b++;
            b.data_in = (qb.size() > 0) ? qb.pop_front() : 8'h00;
        end
        b.queue_empty_in = (qb.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_a(input logic [7:0] w);
        qa.push_back(w); a.queue_empty_in = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] w);
        qb.push_back(w); b.queue_empty_in = 1'b0;
    endtask

    // assemble 8 bits in arrival order, first bit ends in the MSB
    task automatic word_of(input int which, input int start, output logic [7:0] w);
        w = 8'h00;
        for (int i = 0; i < 8; i++)
            w = {w[6:0], (which == 0) ? bits_a[start+i] : bits_b[start+i]};
    endtask

    task automatic clear_logs();
        bits_a.delete(); wcyc_a.delete(); bits_b.delete();
        deq_a = 0; deq_b = 0; done_a = 0; done_pos_a = 0;
    endtask

    initial begin
        reset = 1'b1;
        a.enable_in = 1'b0; a.queue_empty_in = 1'b1; a.data_in = 8'h00; a.ready_in = 1'b1;
        b.enable_in = 1'b0; b.queue_empty_in = 1'b1; b.data_in = 8'h00; b.ready_in = 1'b1;
        ticks(3);
        chk("rst_dequeue", 32'(a.dequeue_out), 32'd0);
        chk("rst_write", 32'(a.write_out), 32'd0);
        chk("rst_data", 32'(a.data_out), 32'd0);
        chk("rst_busy", 32'(a.busy_out), 32'd0);
        chk("rst_done", 32'(a.word_done_out), 32'd0);
        chk("rst_sent", 32'(a.words_sent_out), 32'd0);
        reset = 1'b0;
        tick();
        clear_logs();

        // reset after 4 bits of 0x5A abandons the word
        a.enable_in = 1'b1;
        push_a(8'h5A);
        ticks(7);
        chk("mid_bits_before_rst", 32'(bits_a.size()), 32'd4);
        reset = 1'b1;
        tick();
        chk("mid_rst_write", 32'(a.write_out), 32'd0);
        chk("mid_rst_busy", 32'(a.busy_out), 32'd0);
        chk("mid_rst_data", 32'(a.data_out), 32'd0);
        chk("mid_rst_sent", 32'(a.words_sent_out), 32'd0);
        reset = 1'b0;
        ticks(3);
        chk("mid_no_resume", 32'(a.busy_out), 32'd0);

        // 0xA5 MSB first
        clear_logs();
        t0 = cyc;
        push_a(8'hA5);
        ticks(14);
        chk("a5_deq_count", 32'(deq_a), 32'd1);
        chk("a5_deq_latency", 32'(deq_cyc_a - t0), 32'd1);
        chk("a5_first_write_latency", 32'(wcyc_a[0] - t0), 32'd4);
        chk("a5_bit_count", 32'(bits_a.size()), 32'd8);
        word_of(0, 0, v);
        chk("a5_value", 32'(v), 32'hA5);
        chk("a5_contiguous", 32'(wcyc_a[7] - wcyc_a[0]), 32'd7);
        chk("a5_done_count", 32'(done_a), 32'd1);
        chk("a5_done_on_8th", 32'(done_pos_a), 32'd8);
        chk("a5_sent", 32'(a.words_sent_out), 32'd1);
        chk("a5_busy_after", 32'(a.busy_out), 32'd0);

        // back-to-back 0xFF, 0x00
        clear_logs();
        push_a(8'hFF);
        push_a(8'h00);
        ticks(30);
        chk("b2b_deq_count", 32'(deq_a), 32'd2);
        chk("b2b_bit_count", 32'(bits_a.size()), 32'd16);
        word_of(0, 0, v);
        chk("b2b_word1", 32'(v), 32'hFF);
        word_of(0, 8, v);
        chk("b2b_word2", 32'(v), 32'h00);
        chk("b2b_gap", 32'(wcyc_a[8] - wcyc_a[7] - 1), 32'd3);
        chk("b2b_done_count", 32'(done_a), 32'd2);
        chk("b2b_sent", 32'(a.words_sent_out), 32'd3);

        // 0xC3 with ready low on SHIFT cycles 3..5
        clear_logs();
        push_a(8'hC3);
        ticks(5);
        a.ready_in = 1'b0;
        ticks(2);
        chk("stall_write_low", 32'(a.write_out), 32'd0);
        chk("stall_data_held", 32'(a.data_out), 32'd1);
        tick();
        a.ready_in = 1'b1;
        ticks(12);
        chk("stall_bit_count", 32'(bits_a.size()), 32'd8);
        word_of(0, 0, v);
        chk("stall_value", 32'(v), 32'hC3);
        chk("stall_shift_span", 32'(wcyc_a[7] - wcyc_a[0]), 32'd10);
        chk("stall_gap", 32'(wcyc_a[2] - wcyc_a[1]), 32'd4);
        chk("stall_sent", 32'(a.words_sent_out), 32'd4);

        // empty queue, then enable low with a word waiting
        clear_logs();
        ticks(20);
        chk("empty_no_deq", 32'(deq_a), 32'd0);
        chk("empty_no_write", 32'(bits_a.size()), 32'd0);
        a.enable_in = 1'b0;
        push_a(8'h3C);
        push_a(8'h96);
        ticks(20);
        chk("disabled_no_deq", 32'(deq_a), 32'd0);
        chk("disabled_no_write", 32'(bits_a.size()), 32'd0);
        chk("disabled_busy", 32'(a.busy_out), 32'd0);
        // enable for one fetch only; the word in flight completes
        a.enable_in = 1'b1;
        tick();
        a.enable_in = 1'b0;
        ticks(20);
        chk("drop_en_deq", 32'(deq_a), 32'd1);
        word_of(0, 0, v);
        chk("drop_en_value", 32'(v), 32'h3C);
        chk("drop_en_bits", 32'(bits_a.size()), 32'd8);
        chk("drop_en_left", 32'(qa.size()), 32'd1);
        chk("drop_en_sent", 32'(a.words_sent_out), 32'd5);
        a.enable_in = 1'b1;
        ticks(14);
        word_of(0, 8, v);
        chk("reen_value", 32'(v), 32'h96);
        chk("reen_sent", 32'(a.words_sent_out), 32'd6);

        // LSB-first build with a 2-bit counter
        clear_logs();
        b.enable_in = 1'b1;
        push_b(8'hA5);
        ticks(14);
        word_of(1, 0, v);
        chk("lsb_a5_value", 32'(v), 32'hA5);
        chk("lsb_a5_sent", 32'(b.words_sent_out), 32'd1);
        push_b(8'h01);
        ticks(14);
        chk("lsb_01_first_bit", 32'(bits_b[8]), 32'd1);
        word_of(1, 8, v);
        chk("lsb_01_value", 32'(v), 32'h80);
        chk("lsb_01_sent", 32'(b.words_sent_out), 32'd2);
        push_b(8'h3C);
        ticks(14);
        chk("lsb_sent_max", 32'(b.words_sent_out), 32'd3);
        push_b(8'hF0);
        ticks(14);
        word_of(1, 24, v);
        chk("lsb_f0_value", 32'(v), 32'h0F);
        chk("lsb_sent_wrap", 32'(b.words_sent_out), 32'd0);
        chk("lsb_deq_count", 32'(deq_b), 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
